// File: rtl/calc_pkg.sv
// calc_pkg: shared command, status and state types for the keypad calculator
package calc_pkg;
  typedef enum logic [3:0] {
    DIG0, DIG1, DIG2, DIG3, DIG4, DIG5, DIG6, DIG7, DIG8, DIG9,
    ADD, SUB, MUL, DIV, EQ, BKSP
  } cmd_t;
  typedef enum logic [1:0] {
    ST_ERR   = 2'b00,
    ST_BUSY  = 2'b01,
    ST_READY = 2'b10
  } status_t;
  typedef enum logic [2:0] {ENTRY_A, ENTRY_B, EXEC, CONV, ERR} state_t;
  function automatic longint unsigned pow10(input int n);
    longint unsigned p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction
endpackage

// File: rtl/calc_seq_if.sv
// calc_seq_if: keypad command handshake plus display/scan outputs
//   master drives cmd/cmd_valid; slave (the calculator) drives the rest
interface calc_seq_if #(parameter int W = 30);
  logic [3:0]   cmd;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   status;
  logic         neg;
  logic [W-1:0] digits;
  logic [3:0]   pos;
  logic [3:0]   data;
  modport master (output cmd, cmd_valid, input cmd_ready, status, neg, digits, pos, data);
  modport slave  (input cmd, cmd_valid, output cmd_ready, status, neg, digits, pos, data);
endinterface

// File: rtl/calc_bin2bcd.sv
// calc_bin2bcd: iterative double-dabble binary to NDIG-digit BCD converter
//   start loads bin; done is high in the cycle of the last shift, after which
//   bcd holds the finished image until the next start
module calc_bin2bcd #(
  parameter int W    = 30,
  parameter int NDIG = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [W-1:0]      bin,
  output logic              done,
  output logic [4*NDIG-1:0] bcd
);
  localparam int CW = $clog2(W);
  logic [W-1:0]      sh;
  logic [CW-1:0]     cnt;
  logic              run;
  logic [4*NDIG-1:0] adj;
  always_comb begin
    adj = bcd;
    for (int i = 0; i < NDIG; i++)
      adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  assign done = run && cnt == CW'(W - 1);
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      sh  <= '0;
      bcd <= '0;
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      sh  <= bin;
      bcd <= '0;
      cnt <= '0;
      run <= 1'b1;
    end else if (run) begin
      bcd <= {adj[4*NDIG-2:0], sh[W-1]};
      sh  <= sh << 1;
      cnt <= cnt + 1'b1;
      run <= !done;
    end
endmodule

// File: rtl/calc_seq.sv
// calc_seq: chained NDIG-digit decimal keypad calculator with BCD scan-out
//   clock/reset : rising-edge clock, asynchronous active-high reset
//   io (slave)  : cmd/cmd_valid/cmd_ready keypad handshake; status, neg,
//                 digits (binary magnitude), pos/data (BCD digit scan)
module calc_seq
  import calc_pkg::*;
#(
  parameter int NDIG    = 8,
  parameter int W       = 30,
  parameter bit MUL_SEQ = 1
) (
  input logic       clock,
  input logic       reset,
  calc_seq_if.slave io
);
  localparam int CW = $clog2(W);
  localparam logic [W-1:0] MAXV = W'(pow10(NDIG) - 1);
  localparam logic [W-1:0] LIM  = W'(pow10(NDIG - 1));
  state_t            state, ret;
  cmd_t              c, op, nop;
  logic [W-1:0]      reg_a, reg_b, digits, sh, rem, rem_n, q_n, base;
  logic [2*W-1:0]    acc, acc_n, ma, res;
  logic [W:0]        r1;
  logic [CW-1:0]     cnt;
  logic [3:0]        pos;
  logic [4*NDIG-1:0] bcd;
  logic              neg, nb, chain, valid, cv_start, cv_done;
  logic              is_dig, is_op, go_exec, is_neg, ge, last, fin, err;
  calc_bin2bcd #(.W(W), .NDIG(NDIG)) u_conv (
    .clock (clock),
    .reset (reset),
    .start (cv_start),
    .bin   (digits),
    .done  (cv_done),
    .bcd   (bcd)
  );
  assign c            = cmd_t'(io.cmd);
  assign is_dig       = io.cmd < 4'd10;
  assign is_op        = c inside {ADD, SUB, MUL, DIV};
  // the first digit of operand B replaces whatever is on display (e.g. a chained result)
  assign base         = state == ENTRY_B && !nb ? '0 : digits;
  assign go_exec      = state == ENTRY_B && (c == EQ || (is_op && nb));
  assign io.cmd_ready = state == ENTRY_A || state == ENTRY_B;
  assign io.status    = state == ERR ? ST_ERR : io.cmd_ready ? ST_READY : ST_BUSY;
  assign io.neg       = neg;
  assign io.digits    = digits;
  assign io.pos       = pos;
  assign io.data      = valid ? 4'(bcd >> {pos, 2'b00}) : 4'd0;
  always_comb begin
    is_neg = op == SUB && reg_a < reg_b;
    acc_n  = acc + (sh[0] ? ma : '0);
    r1     = {rem, sh[W-1]};
    ge     = r1 >= {1'b0, reg_b};
    rem_n  = ge ? W'(r1 - {1'b0, reg_b}) : r1[W-1:0];
    q_n    = {sh[W-2:0], ge};
    last   = cnt == CW'(W - 1);
    res    = op == ADD ? (2*W)'(reg_a) + (2*W)'(reg_b) :
             op == SUB ? (2*W)'(is_neg ? reg_b - reg_a : reg_a - reg_b) :
             op == MUL ? (MUL_SEQ ? acc_n : (2*W)'(reg_a) * (2*W)'(reg_b)) : (2*W)'(q_n);
    fin    = op == ADD || op == SUB || (op == MUL && (!MUL_SEQ || last)) ||
             (op == DIV && (reg_b == '0 || last));
    err    = (op == DIV && reg_b == '0) || res > (2*W)'(MAXV) || (chain && is_neg);
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state    <= ENTRY_A;
      ret      <= ENTRY_A;
      op       <= ADD;
      nop      <= ADD;
      reg_a    <= '0;
      reg_b    <= '0;
      digits   <= '0;
      neg      <= 1'b0;
      nb       <= 1'b0;
      chain    <= 1'b0;
      valid    <= 1'b0;
      cv_start <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      ma       <= '0;
      sh       <= '0;
      rem      <= '0;
      pos      <= '0;
    end else begin
      cv_start <= 1'b0;
      pos      <= pos == 4'(NDIG - 1) ? 4'd0 : pos + 4'd1;
      case (state)
        ENTRY_A, ENTRY_B: if (io.cmd_valid) begin
          valid <= 1'b0;
          if (go_exec) begin
            reg_b <= digits;
            chain <= c != EQ;
            nop   <= c;
            state <= EXEC;
            cnt   <= '0;
            acc   <= '0;
            rem   <= '0;
            ma    <= (2*W)'(reg_a);
            // shift register holds the multiplier, or the dividend that becomes the quotient
            sh    <= op == DIV ? reg_a : digits;
          end else begin
            state    <= CONV;
            ret      <= state;
            cv_start <= 1'b1;
            if (is_dig) begin
              if (base < LIM) begin
                digits <= base * W'(10) + W'(io.cmd);
                nb     <= 1'b1;
              end
              neg <= 1'b0;
            end else if (c == BKSP) begin
              digits <= digits / W'(10);
              neg    <= 1'b0;
            end else if (is_op) begin
              op <= c;
              if (state == ENTRY_A) begin
                reg_a  <= digits;
                digits <= '0;
                nb     <= 1'b0;
                neg    <= 1'b0;
                ret    <= ENTRY_B;
              end
            end
          end
        end
        EXEC: begin
          cnt <= cnt + 1'b1;
          acc <= acc_n;
          ma  <= ma << 1;
          sh  <= op == DIV ? q_n : sh >> 1;
          rem <= rem_n;
          if (fin) begin
            if (err) begin
              state  <= ERR;
              digits <= '0;
              neg    <= 1'b0;
            end else begin
              state    <= CONV;
              cv_start <= 1'b1;
              digits   <= res[W-1:0];
              neg      <= is_neg;
              ret      <= chain ? ENTRY_B : ENTRY_A;
              if (chain) begin
                reg_a <= res[W-1:0];
                op    <= nop;
                nb    <= 1'b0;
              end
            end
          end
        end
        CONV: if (cv_done) begin
          state <= ret;
          valid <= 1'b1;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_calc_seq.sv
// tb_calc_seq: table-driven and randomized checks of calc_seq against a decimal arithmetic model
module tb_calc_seq;
  localparam int NDIG = 8;
  localparam int W    = 30;
  localparam longint MAXV = 99999999;
  typedef struct {
    string  keys;
    longint dig;
    bit     neg;
    int     st;
  } vec_t;
  logic clock = 0;
  logic reset = 1;
  int nvec = 0;
  int nmis = 0;
  calc_seq_if #(.W(W)) bus();
  calc_seq #(.NDIG(NDIG), .W(W), .MUL_SEQ(1)) dut (.clock(clock), .reset(reset), .io(bus.slave));
  always #5 clock = ~clock;
  task automatic check(input string name, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask
  function automatic logic [3:0] key_of(input byte ch);
    case (ch)
      "+": return 4'hA;
      "-": return 4'hB;
      "*": return 4'hC;
      "/": return 4'hD;
      "=": return 4'hE;
      "F": return 4'hF;
      default: return 4'(ch - "0");
    endcase
  endfunction
  task automatic do_reset();
    @(negedge clock);
    reset = 1;
    bus.cmd_valid = 0;
    bus.cmd = 0;
    @(negedge clock);
    reset = 0;
  endtask
  task automatic press(input logic [3:0] k);
    int t = 0;
    while (!bus.cmd_ready && bus.status != 2'b00 && t < 3000) begin
      @(negedge clock);
      t++;
    end
    if (t >= 3000) check("press_timeout", t, 0);
    if (bus.cmd_ready) begin
      bus.cmd = k;
      bus.cmd_valid = 1;
      @(negedge clock);
      bus.cmd_valid = 0;
    end
  endtask
  task automatic settle();
    int t = 0;
    while (!bus.cmd_ready && bus.status != 2'b00 && t < 3000) begin
      @(negedge clock);
      t++;
    end
    if (t >= 3000) check("settle_timeout", t, 0);
  endtask
  task automatic apply(input string s);
    for (int i = 0; i < s.len(); i++) press(key_of(s[i]));
    settle();
  endtask
  task automatic check_scan(input string name, input longint v, input bit bad);
    for (int i = 0; i < NDIG; i++) begin
      longint p = 1;
      for (int k = 0; k < int'(bus.pos); k++) p = p * 10;
      check({name, "_data"}, bus.data, bad ? 0 : (v / p) % 10);
      @(negedge clock);
    end
  endtask
  vec_t tv[$];
  initial begin
    int busy;
    bus.cmd = 0;
    bus.cmd_valid = 0;
    tv.push_back('{"123F4",        124,      0, 2});
    tv.push_back('{"999999999",    99999999, 0, 2});
    tv.push_back('{"12+30=",       42,       0, 2});
    tv.push_back('{"5-7=",         2,        1, 2});
    tv.push_back('{"123*45=",      5535,     0, 2});
    tv.push_back('{"6*7+8=",       50,       0, 2});
    tv.push_back('{"9/0=",         0,        0, 0});
    tv.push_back('{"99999999+1=",  0,        0, 0});
    tv.push_back('{"100/7=",       14,       0, 2});
    tv.push_back('{"5-7=3",        23,       0, 2});
    tv.push_back('{"5-7+1=",       0,        0, 0});
    tv.push_back('{"9+-3=",        6,        0, 2});
    tv.push_back('{"12*3*",        36,       0, 2});
    tv.push_back('{"4=",           4,        0, 2});
    tv.push_back('{"99999*99999=", 0,        0, 0});
    tv.push_back('{"3+=",          3,        0, 2});
    #12;
    check("reset_status", bus.status, 2);
    check("reset_ready", bus.cmd_ready, 1);
    check("reset_digits", bus.digits, 0);
    check("reset_neg", bus.neg, 0);
    check("reset_pos", bus.pos, 0);
    check("reset_data", bus.data, 0);
    @(negedge clock);
    reset = 0;
    foreach (tv[i]) begin
      do_reset();
      apply(tv[i].keys);
      check({"vec_", tv[i].keys, "_digits"}, bus.digits, tv[i].dig);
      check({"vec_", tv[i].keys, "_neg"}, bus.neg, tv[i].neg);
      check({"vec_", tv[i].keys, "_status"}, bus.status, tv[i].st);
      check_scan({"vec_", tv[i].keys}, tv[i].dig, tv[i].st == 0);
    end
    // multiply latency with cmd_valid held high the whole time: the held key must be dropped
    do_reset();
    apply("123*45");
    press(4'hE);
    bus.cmd = 4'd7;
    bus.cmd_valid = 1;
    busy = 0;
    while (bus.status == 2'b01 && busy < 500) begin
      busy++;
      @(negedge clock);
    end
    bus.cmd_valid = 0;
    check("mul_busy_cycles", busy, 2 * W + 1);
    check("mul_held_key_dropped", bus.digits, 5535);
    // error is sticky until reset
    do_reset();
    apply("9/0=");
    repeat (20) @(negedge clock);
    apply("12+3=");
    check("err_hold_status", bus.status, 0);
    check("err_hold_digits", bus.digits, 0);
    reset = 1;
    #1;
    check("err_reset_status", bus.status, 2);
    check("err_reset_pos", bus.pos, 0);
    @(negedge clock);
    reset = 0;
    // asynchronous reset between clock edges in the middle of a divide
    apply("99999999/7");
    press(4'hE);
    repeat (10) @(negedge clock);
    check("div_busy", bus.status, 1);
    #2;
    reset = 1;
    #1;
    check("async_status", bus.status, 2);
    check("async_ready", bus.cmd_ready, 1);
    check("async_digits", bus.digits, 0);
    check("async_neg", bus.neg, 0);
    check("async_pos", bus.pos, 0);
    check("async_data", bus.data, 0);
    @(negedge clock);
    reset = 0;
    // randomized single operations against plain decimal arithmetic
    for (int n = 0; n < 30; n++) begin
      longint a, b, r, pa, pb;
      int o;
      bit bad, ng;
      string s;
      pa = 1;
      pb = 1;
      for (int k = $urandom_range(1, 8); k > 0; k--) pa = pa * 10;
      for (int k = $urandom_range(1, 5); k > 0; k--) pb = pb * 10;
      a = longint'($urandom) % pa;
      b = longint'($urandom) % pb;
      o = $urandom_range(0, 3);
      ng = 0;
      bad = 0;
      case (o)
        0: r = a + b;
        1: begin ng = a < b; r = ng ? b - a : a - b; end
        2: r = a * b;
        default: begin bad = b == 0; r = bad ? 0 : a / b; end
      endcase
      if (r > MAXV) bad = 1;
      if (bad) begin r = 0; ng = 0; end
      s = $sformatf("%0d%s%0d=", a, o == 0 ? "+" : o == 1 ? "-" : o == 2 ? "*" : "/", b);
      do_reset();
      apply(s);
      check({"rnd_", s, "_digits"}, bus.digits, r);
      check({"rnd_", s, "_neg"}, bus.neg, ng);
      check({"rnd_", s, "_status"}, bus.status, bad ? 0 : 2);
      check_scan({"rnd_", s}, r, bad);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
